ps2_kbd_tx: RTL and testbench

PS/2 device-side transmitter: accepts keyboard scancode bytes from the core's keyboard front end and serializes them onto a PS/2 clock/data pair in 11-bit device-to-host frames. It feeds the motherboard's PS2_CLK/PS2_DATA inputs, the end that normally receives the bus. A small FIFO absorbs make/break bursts such as E0-prefixed and F0 sequences. Bit timing derives from a clock-enable tick so the same block runs from any ce_* strobe of clk_sys.

---
 rtl/ps2_kbd_tx_if.sv | 16 +
 rtl/ps2_kbd_tx.sv | 156 +++++++++++++++
 tb/tb_ps2_kbd_tx.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_tx_if.sv
// ps2_kbd_tx_if: byte-push handshake between the keyboard front end and the
// PS/2 device-side transmitter.
//   din        scancode byte offered by the producer
//   din_valid  producer push request
//   din_ready  transmitter FIFO has room
//   overflow   one-cycle pulse after a push was attempted while full
// master = producer (front end), slave = ps2_kbd_tx.
interface ps2_kbd_tx_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       overflow;

  modport master (output din, output din_valid, input din_ready, input overflow);
  modport slave  (input din, input din_valid, output din_ready, output overflow);
endinterface

// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: PS/2 device-side transmitter. Scancode bytes are queued in a
// small FIFO and serialized as 11-bit device-to-host frames
// (start 0, D0..D7 LSB first, odd parity, stop 1). All bit timing is counted
// in ce ticks so the block can run from any clock-enable strobe.
// Ports:
//   clk_sys   system clock, all logic on posedge
//   reset     asynchronous active-high reset (flushes FIFO, abandons frame)
//   ce        timing tick; the serializer advances only when high
//   bus       byte push handshake (din, din_valid, din_ready, overflow)
//   busy      serializer active or bytes still queued
//   ps2_clk   PS/2 clock output, idle high
//   ps2_data  PS/2 data output, idle high
module ps2_kbd_tx #(
  parameter int HALF_TICKS = 8,
  parameter int GAP_TICKS  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         ce,
  ps2_kbd_tx_if.slave  bus,
  output logic         busy,
  output logic         ps2_clk,
  output logic         ps2_data
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (HALF_TICKS > GAP_TICKS) ? HALF_TICKS : GAP_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [PTR_W:0] FULL      = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [PTR_W:0]   count_reg;
  logic             overflow_reg;
  logic             push, pop;
  logic [7:0]       head_byte;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       bitn_reg;
  logic [10:0]      shifter_reg;
  logic             ps2_clk_reg, ps2_data_reg;

  assign bus.din_ready = (count_reg != FULL);
  assign bus.overflow  = overflow_reg;

  // Acceptance looks only at the registered count, so a push into a full
  // FIFO is refused even when a pop frees a slot on the same edge.
  assign push = bus.din_valid && bus.din_ready;
  assign pop  = ce && (state_reg == IDLE) && (count_reg != '0);

  // The head byte must be available on the same edge it is popped so the
  // start bit can be driven immediately; the FIFO is tiny, so an
  // asynchronous read of the array is used here.
  assign head_byte = mem[head_reg];

  always_ff @(posedge clk_sys) begin
    if (push)
      mem[tail_reg] <= bus.din;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= bus.din_valid && !bus.din_ready;
      if (push)
        tail_reg <= tail_reg + 1'b1;
      if (pop)
        head_reg <= head_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------- serializer
  // shifter_reg[0] is always the bit currently on ps2_data; the register is
  // refilled with ones from the top so the stop bit falls out naturally.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      bitn_reg     <= '0;
      shifter_reg  <= '1;
      ps2_clk_reg  <= 1'b1;
      ps2_data_reg <= 1'b1;
    end else if (ce) begin
      case (state_reg)
        IDLE: begin
          if (count_reg != '0) begin
            shifter_reg  <= {1'b1, ~^head_byte, head_byte, 1'b0};
            ps2_data_reg <= 1'b0;
            cnt_reg      <= '0;
            bitn_reg     <= '0;
            state_reg    <= HIGH;
          end
        end
        HIGH: begin
          if (cnt_reg == HALF_LAST) begin
            ps2_clk_reg <= 1'b0;
            cnt_reg     <= '0;
            state_reg   <= LOW;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        LOW: begin
          if (cnt_reg == HALF_LAST) begin
            ps2_clk_reg <= 1'b1;
            cnt_reg     <= '0;
            if (bitn_reg == 4'd10) begin
              ps2_data_reg <= 1'b1;
              state_reg    <= GAP;
            end else begin
              // Data changes together with the rising clock edge, so it is
              // stable across the whole following low phase.
              bitn_reg     <= bitn_reg + 1'b1;
              shifter_reg  <= {1'b1, shifter_reg[10:1]};
              ps2_data_reg <= shifter_reg[1];
              state_reg    <= HIGH;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        GAP: begin
          if (cnt_reg == GAP_LAST) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ps2_clk  = ps2_clk_reg;
  assign ps2_data = ps2_data_reg;
  assign busy     = (state_reg != IDLE) || (count_reg != '0);

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// tb_ps2_kbd_tx: self-checking bench for ps2_kbd_tx. A behavioural model
// tracks the queued bytes and, for the frame in flight, the number of ce
// ticks since its pop; the expected line levels are derived arithmetically
// from that tick position. A decoder also reassembles frames at ps2_clk
// falling edges and checks them against the bytes the model popped.
module tb_ps2_kbd_tx;

  localparam int H     = 8;
  localparam int G     = 16;
  localparam int DEPTH = 4;
  localparam int BIT   = 2 * H;
  localparam int DATA_TICKS  = 11 * BIT;
  localparam int FRAME_TICKS = 22 * H + G;

  logic clk_sys = 1'b0;
  logic reset   = 1'b0;
  logic ce      = 1'b0;
  logic busy, ps2_clk, ps2_data;

  ps2_kbd_tx_if bus ();

  ps2_kbd_tx #(.HALF_TICKS(H), .GAP_TICKS(G), .FIFO_DEPTH(DEPTH)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ce       (ce),
    .bus      (bus),
    .busy     (busy),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [7:0] q[$];
  logic [7:0] sent_q[$];
  logic [7:0] cur;
  bit         act;
  int         k;
  bit         exp_ovf;
  int         phase;

  // frame decoder state
  logic [10:0] rx_bits;
  int          nb;
  logic        prev_clk;
  int          n_frames;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9) return ($countones(b) % 2) == 0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    sent_q.delete();
    act = 0;
    k = 0;
    exp_ovf = 0;
    nb = 0;
    prev_clk = 1'b1;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d, input logic c);
    int pre;
    pre = q.size();
    exp_ovf = v && (pre == DEPTH);
    if (c) begin
      if (act) begin
        k++;
        if (k == FRAME_TICKS) act = 0;
      end else if (pre > 0) begin
        cur = q.pop_front();
        sent_q.push_back(cur);
        act = 1;
        k = 0;
      end
    end
    if (v && pre != DEPTH) q.push_back(d);
  endtask

  task automatic check_outputs();
    logic e_clk, e_dat;
    e_clk = 1'b1;
    e_dat = 1'b1;
    if (act && k < DATA_TICKS) begin
      e_clk = (k % BIT) < H;
      e_dat = exp_bit(cur, k / BIT);
    end
    chk("ps2_clk",   32'(ps2_clk),       32'(e_clk));
    chk("ps2_data",  32'(ps2_data),      32'(e_dat));
    chk("busy",      32'(busy),          32'(act || q.size() != 0));
    chk("din_ready", 32'(bus.din_ready), 32'(q.size() != DEPTH));
    chk("overflow",  32'(bus.overflow),  32'(exp_ovf));
  endtask

  task automatic decode();
    logic [7:0] eb;
    if (prev_clk === 1'b1 && ps2_clk === 1'b0) begin
      rx_bits[nb] = ps2_data;
      nb++;
      if (nb == 11) begin
        nb = 0;
        n_frames++;
        if (sent_q.size() == 0) begin
          chk("frame_without_pop", 32'(sent_q.size()), 32'd1);
        end else begin
          eb = sent_q.pop_front();
          chk("frame_start",  32'(rx_bits[0]),   32'd0);
          chk("frame_byte",   32'(rx_bits[8:1]), 32'(eb));
          chk("frame_parity", 32'(rx_bits[9]),   32'(($countones(eb) % 2) == 0));
          chk("frame_stop",   32'(rx_bits[10]),  32'd1);
          $display("frame %0d: byte %02h parity %0b at %0t", n_frames, rx_bits[8:1], rx_bits[9], $time);
        end
      end
    end
    prev_clk = ps2_clk;
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic c);
    @(negedge clk_sys);
    bus.din_valid = v;
    bus.din       = d;
    ce            = c;
    @(posedge clk_sys);
    if (!reset) model_edge(v, d, c);
    #1;
    check_outputs();
    decode();
  endtask

  // ce on every 4th cycle; a held cycle forces ce low and freezes the phase.
  task automatic tick_step(input logic v, input logic [7:0] d, input logic hold);
    step(v, d, !hold && phase == 0);
    if (!hold) phase = (phase + 1) % 4;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      step(1'b0, 8'h00, 1'b1);
      n++;
    end
    chk("drain_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int n, w;
    bus.din_valid = 1'b0;
    bus.din       = 8'h00;
    n_frames      = 0;
    phase         = 0;
    model_reset();

    // reset state
    #1 reset = 1'b1;
    #1;
    chk("rst_ps2_clk",   32'(ps2_clk),       32'd1);
    chk("rst_ps2_data",  32'(ps2_data),      32'd1);
    chk("rst_din_ready", 32'(bus.din_ready), 32'd1);
    chk("rst_overflow",  32'(bus.overflow),  32'd0);
    chk("rst_busy",      32'(busy),          32'd0);
    repeat (2) step(1'b0, 8'h00, 1'b0);
    @(negedge clk_sys) reset = 1'b0;

    // single byte 0x1C, busy low 193 cycles after the push
    step(1'b1, 8'h1C, 1'b1);
    n = 0;
    while (busy && n < 400) begin
      step(1'b0, 8'h00, 1'b1);
      n++;
    end
    chk("busy_len_1c", 32'(n), 32'd193);

    // 0x00 then 0xFF back to back
    step(1'b1, 8'h00, 1'b1);
    step(1'b1, 8'hFF, 1'b1);
    drain(600);

    // five pushes accepted, sixth overflows
    for (int i = 0; i < 5; i++) step(1'b1, 8'h30 + 8'(i), 1'b1);
    step(1'b1, 8'hEE, 1'b1);
    chk("sixth_overflow", 32'(bus.overflow), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("overflow_one_cycle", 32'(bus.overflow), 32'd0);
    drain(1500);

    // asynchronous reset during bit 4 with two bytes queued
    for (int i = 0; i < 3; i++) step(1'b1, 8'hA0 + 8'(i), 1'b1);
    n = 0;
    while (!(act && k == 4 * BIT + H + 2) && n < 200) begin
      step(1'b0, 8'h00, 1'b1);
      n++;
    end
    chk("reached_bit4", 32'(act && k == 4 * BIT + H + 2), 32'd1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async_ps2_clk",   32'(ps2_clk),       32'd1);
    chk("async_ps2_data",  32'(ps2_data),      32'd1);
    chk("async_din_ready", 32'(bus.din_ready), 32'd1);
    chk("async_busy",      32'(busy),          32'd0);
    repeat (3) step(1'b0, 8'h00, 1'b0);
    @(negedge clk_sys) reset = 1'b0;
    repeat (400) step(1'b0, 8'h00, 1'b1);

    // ce every 4th cycle: 768 cycles from pop to idle
    phase = 0;
    tick_step(1'b1, 8'h5A, 1'b0);
    n = 0;
    while (ps2_data && n < 100) begin
      tick_step(1'b0, 8'h00, 1'b0);
      n++;
    end
    n = 0;
    while (busy && n < 2000) begin
      tick_step(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("frame_cycles_ce4", 32'(n), 32'd768);

    // ce held low for 100 cycles inside the first low phase
    tick_step(1'b1, 8'hC3, 1'b0);
    n = 0;
    while (ps2_clk && n < 200) begin
      tick_step(1'b0, 8'h00, 1'b0);
      n++;
    end
    w = 0;
    repeat (2) begin tick_step(1'b0, 8'h00, 1'b0); w++; end
    repeat (100) begin tick_step(1'b0, 8'h00, 1'b1); w++; end
    while (!ps2_clk && w < 400) begin
      tick_step(1'b0, 8'h00, 1'b0);
      w++;
    end
    chk("low_phase_hold", 32'(w), 32'd132);
    n = 0;
    while (busy && n < 2000) begin
      tick_step(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("hold_frame_done", 32'(busy), 32'd0);

    // simultaneous push and pop at count DEPTH-1
    for (int i = 0; i < 3; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
    step(1'b1, 8'h13, 1'b1);
    chk("pushpop_ready",    32'(bus.din_ready), 32'd1);
    chk("pushpop_overflow", 32'(bus.overflow),  32'd0);
    step(1'b1, 8'h14, 1'b0);
    chk("pushpop_now_full", 32'(bus.din_ready), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    drain(1200);

    // randomized traffic with random ce
    for (int i = 0; i < 4000; i++)
      step(($urandom % 8) == 0, 8'($urandom), ($urandom % 4) != 0);
    drain(1500);
    chk("all_frames_seen", 32'(sent_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
